// File: rtl/fpu_zhinx_issue_unit.sv
// Zhinx FP16 issue front end.
// Takes one FP op at a time from the integer pipeline, launches it on an
// external variable-latency core, and queues the sign-extended result with
// its tag in a small first-word-fall-through response FIFO. A watchdog turns
// a hung core into a canonical-NaN response flagged with rsp_timeout.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | ready for a request when a FIFO slot is free
//   ST_ISSUE | one-cycle core_start pulse, watchdog counter cleared
//   ST_WAIT  | waiting for core_done or watchdog expiry
module fpu_zhinx_issue_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned OP_W        = 5,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [OP_W-1:0]  operation,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  output logic             core_start,
  output logic [OP_W-1:0]  core_op,
  output logic [15:0]      core_a,
  output logic [15:0]      core_b,
  input  logic             core_done,
  input  logic [15:0]      core_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [XLEN-1:0]  rsp_out,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TO_M1 = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_M1[CNT_W-1:0];
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned FC_W = $clog2(RSP_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [FC_W-1:0] FIFO_FULL = FC_W'(RSP_DEPTH);
  localparam logic [15:0] CANON_NAN = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic core_start_q, core_start_d;

  logic push;
  logic pop;
  logic [15:0] push_res;
  logic push_to;
  logic timeout_hit;

  logic [FC_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0] mem_tag_q [RSP_DEPTH];
  logic [TAG_W-1:0] mem_tag_d [RSP_DEPTH];
  logic [15:0] mem_res_q [RSP_DEPTH];
  logic [15:0] mem_res_d [RSP_DEPTH];
  logic mem_to_q [RSP_DEPTH];
  logic mem_to_d [RSP_DEPTH];

  // Only the low half of each operand feeds the FP16 core.
  logic unused_operand_hi;
  assign unused_operand_hi = ^{req_a[XLEN-1:16], req_b[XLEN-1:16]};

  // A free FIFO slot is reserved at accept, so a later push can never overflow.
  assign req_ready = nRST && (state_q == ST_IDLE) && (count_q < FIFO_FULL);
  assign busy = (state_q != ST_IDLE);
  assign core_start = core_start_q;
  assign core_op = op_q;
  assign core_a = a_q;
  assign core_b = b_q;

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  // Sequencer next-state: latch at accept, pulse start, then wait for done or watchdog.
  always_comb begin
    state_d = state_q;
    tag_d = tag_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    core_start_d = 1'b0;
    push = 1'b0;
    push_res = 16'h0000;
    push_to = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          tag_d = req_tag;
          op_d = operation;
          a_d = req_a[15:0];
          b_d = req_b[15:0];
          core_start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the expiry cycle still beats the watchdog.
        if (core_done) begin
          push = 1'b1;
          push_res = core_out;
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          push = 1'b1;
          push_res = CANON_NAN;
          push_to = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers, including the registered core-side outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      tag_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      core_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      core_start_q <= core_start_d;
    end
  end

  // Response FIFO next-state: circular buffer, pop before push keeps order.
  always_comb begin
    pop = rsp_valid && rsp_ready;
    count_d = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_tag_d = mem_tag_q;
    mem_res_d = mem_res_q;
    mem_to_d = mem_to_q;
    if (push) begin
      mem_tag_d[wr_ptr_q] = tag_q;
      mem_res_d[wr_ptr_q] = push_res;
      mem_to_d[wr_ptr_q] = push_to;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + FC_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - FC_W'(1);
    end
  end

  // FIFO pointers and occupancy; reset empties the queue.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are never visible while empty, so no reset needed.
  always_ff @(posedge CLK) begin
    mem_tag_q <= mem_tag_d;
    mem_res_q <= mem_res_d;
    mem_to_q <= mem_to_d;
  end

  assign rsp_valid = (count_q != '0);
  assign rsp_tag = rsp_valid ? mem_tag_q[rd_ptr_q] : '0;
  assign rsp_out = rsp_valid ? {{(XLEN-16){mem_res_q[rd_ptr_q][15]}}, mem_res_q[rd_ptr_q]} : '0;
  assign rsp_timeout = rsp_valid ? mem_to_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_fpu_zhinx_issue_unit.sv
// Bench for fpu_zhinx_issue_unit: directed vector table, hand-written corner
// sequences, and a randomized run against a timeline-based reference model.
module tb_fpu_zhinx_issue_unit;
  localparam int XLEN = 32;
  localparam int TAG_W = 4;
  localparam int OP_W = 5;
  localparam int DEPTH = 4;
  localparam int TMO = 8;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [TAG_W-1:0] req_tag = '0;
  logic [OP_W-1:0] operation = '0;
  logic [XLEN-1:0] req_a = '0;
  logic [XLEN-1:0] req_b = '0;
  logic core_start;
  logic [OP_W-1:0] core_op;
  logic [15:0] core_a;
  logic [15:0] core_b;
  logic core_done = 1'b0;
  logic [15:0] core_out = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [TAG_W-1:0] rsp_tag;
  logic [XLEN-1:0] rsp_out;
  logic rsp_timeout;
  logic busy;

  fpu_zhinx_issue_unit #(
    .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .RSP_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .operation(operation), .req_a(req_a), .req_b(req_b),
    .core_start(core_start), .core_op(core_op), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_out(rsp_out), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [4:0]  op;
    logic [15:0] res;
    int          lat;     // WAIT cycle carrying core_done; 0 = never
    logic [31:0] exp_out;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] out;
    logic        to;
  } rsp_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    req_valid = 1'b0;
    core_done = 1'b0;
    rsp_ready = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int r;
    r = (v.lat >= 1 && v.lat <= TMO) ? v.lat : TMO;
    req_valid = 1'b1;
    req_tag = v.tag;
    operation = v.op;
    req_a = v.a;
    req_b = v.b;
    #1;
    chk("vec_idle_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("vec_start", core_start, 1);
    chk("vec_core_op", core_op, v.op);
    chk("vec_core_a", core_a, v.a[15:0]);
    chk("vec_core_b", core_b, v.b[15:0]);
    for (int j = 1; j <= r + 2; j++) begin
      tick();
      core_done = (j == v.lat);
      core_out = v.res;
      if (j <= r) begin
        chk("vec_wait_busy", busy, 1);
        chk("vec_wait_start", core_start, 0);
        chk("vec_wait_rsp", rsp_valid, 0);
      end else if (j == r + 1) begin
        chk("vec_rsp_valid", rsp_valid, 1);
        chk("vec_rsp_out", rsp_out, v.exp_out);
        chk("vec_rsp_tag", rsp_tag, v.tag);
        chk("vec_rsp_timeout", rsp_timeout, v.exp_to);
        chk("vec_rsp_idle", busy, 0);
        rsp_ready = 1'b1;
      end else begin
        chk("vec_popped", rsp_valid, 0);
        rsp_ready = 1'b0;
      end
    end
    tick();
    core_done = 1'b0;
    chk("vec_no_extra_rsp", rsp_valid, 0);
    chk("vec_idle_after", busy, 0);
  endtask

  // Accept one op and answer it in the first WAIT cycle; ends in IDLE with the entry queued.
  task automatic issue_simple(input logic [3:0] tag, input logic [15:0] res);
    req_valid = 1'b1;
    req_tag = tag;
    operation = 5'd2;
    req_a = 32'h0;
    req_b = 32'h0;
    chk("simple_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick();
    core_done = 1'b1;
    core_out = res;
    tick();
    core_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rsp_t expq[$];
    rsp_t r;
    bit done_at[int];
    bit outst;
    bit p_to;
    int t_acc;
    int t_res;
    int lat;
    logic [3:0] p_tag;
    logic [4:0] p_op;
    logic [15:0] p_a, p_b, p_res;
    logic e_ready, e_start, acc;

    vecs[0] = '{32'hFFFF_3C00, 32'h0000_4000, 4'd3, 5'd1, 16'hC200, 5,  32'hFFFF_C200, 1'b0};
    vecs[1] = '{32'h1234_0001, 32'hABCD_7BFF, 4'd5, 5'd2, 16'h3C00, 1,  32'h0000_3C00, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 4'd7, 5'd3, 16'h8000, 2,  32'hFFFF_8000, 1'b0};
    vecs[3] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 4'd9, 5'd4, 16'h7FFF, 8,  32'h0000_7FFF, 1'b0};
    vecs[4] = '{32'h0000_1111, 32'h0000_2222, 4'hA, 5'd5, 16'h1234, 0,  32'h0000_7E00, 1'b1};
    vecs[5] = '{32'h5555_AAAA, 32'hAAAA_5555, 4'hF, 5'd6, 16'hFFFF, 10, 32'h0000_7E00, 1'b1};
    vecs[6] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'd0, 5'd7, 16'h0001, 9,  32'h0000_7E00, 1'b1};
    vecs[7] = '{32'h8000_8000, 32'h7FFF_7FFF, 4'hC, 5'd31, 16'h0000, 7, 32'h0000_0000, 1'b0};

    // Reset state, checked while nRST is still held low.
    tick();
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_op", core_op, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_core_b", core_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_out", rsp_out, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    nRST = 1'b1;
    #1;
    chk("rst_release_ready", req_ready, 1);

    // Directed vector table.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // FIFO fill with consumer stalled, then in-order drain.
    do_reset();
    for (int k = 0; k < DEPTH; k++) issue_simple(4'(k), 16'h1000 + 16'(k));
    chk("full_ready", req_ready, 0);
    chk("full_valid", rsp_valid, 1);
    req_valid = 1'b1;
    req_tag = 4'hE;
    tick();
    tick();
    chk("full_hold_ready", req_ready, 0);
    chk("full_no_accept", busy, 0);
    req_valid = 1'b0;
    chk("full_head_tag", rsp_tag, 0);
    chk("full_head_out", rsp_out, 32'h0000_1000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("ready_after_pop", req_ready, 1);
    for (int k = 1; k < DEPTH; k++) begin
      chk("order_tag", rsp_tag, k);
      chk("order_out", rsp_out, 32'h0000_1000 + 32'(k));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    chk("drain_empty", rsp_valid, 0);

    // Reset while waiting with two entries queued; a later core_done is dropped.
    do_reset();
    issue_simple(4'd5, 16'h1111);
    issue_simple(4'd6, 16'h2222);
    req_valid = 1'b1;
    req_tag = 4'd7;
    operation = 5'h1F;
    req_a = 32'h0000_FFFF;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_count", rsp_valid, 1);
    do_reset();
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_core_op", core_op, 0);
    chk("midrst_core_a", core_a, 0);
    chk("midrst_rsp_out", rsp_out, 0);
    core_done = 1'b1;
    core_out = 16'hABCD;
    tick();
    core_done = 1'b0;
    tick();
    chk("late_done_valid", rsp_valid, 0);
    chk("late_done_busy", busy, 0);

    // Push and pop on the same edge leave the occupancy unchanged.
    do_reset();
    issue_simple(4'd1, 16'h00AA);
    req_valid = 1'b1;
    req_tag = 4'd2;
    tick();
    req_valid = 1'b0;
    tick();
    core_done = 1'b1;
    core_out = 16'h00BB;
    rsp_ready = 1'b1;
    tick();
    core_done = 1'b0;
    rsp_ready = 1'b0;
    chk("pp_valid", rsp_valid, 1);
    chk("pp_tag", rsp_tag, 2);
    chk("pp_out", rsp_out, 32'h0000_00BB);
    chk("pp_ready", req_ready, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("pp_empty", rsp_valid, 0);

    // Back-to-back ops with a 1-cycle core: one response every 3 cycles.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    operation = 5'd0;
    for (int c = 0; c < 15; c++) begin
      chk("tp_start", core_start, 64'(c % 3 == 1));
      chk("tp_valid", rsp_valid, 64'(c > 0 && c % 3 == 0));
      if (c > 0 && c % 3 == 0) chk("tp_tag", rsp_tag, 64'(c / 3 - 1));
      req_tag = 4'(c / 3);
      core_done = (c % 3 == 2);
      core_out = 16'(c);
      tick();
    end
    req_valid = 1'b0;
    core_done = 1'b0;
    tick();
    tick();
    chk("tp_idle_busy", busy, 0);
    chk("tp_idle_valid", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Randomized run against a timeline model: an op accepted at cycle T
    // starts the core in T+1, its done (latency L) lands in T+1+L, and it
    // resolves in T+1+min(L,TMO); the response shows up one cycle later.
    do_reset();
    outst = 1'b0;
    p_to = 1'b0;
    t_acc = -10;
    t_res = -10;
    p_tag = '0;
    p_op = '0;
    p_a = '0;
    p_b = '0;
    p_res = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      e_ready = !outst && (expq.size() < DEPTH);
      e_start = outst && (cyc == t_acc + 1);
      chk("rnd_req_ready", req_ready, e_ready);
      chk("rnd_busy", busy, outst);
      chk("rnd_core_start", core_start, e_start);
      chk("rnd_rsp_valid", rsp_valid, 64'(expq.size() != 0));
      if (expq.size() != 0) begin
        chk("rnd_rsp_tag", rsp_tag, expq[0].tag);
        chk("rnd_rsp_out", rsp_out, expq[0].out);
        chk("rnd_rsp_timeout", rsp_timeout, expq[0].to);
      end
      if (e_start) begin
        chk("rnd_core_op", core_op, p_op);
        chk("rnd_core_a", core_a, p_a);
        chk("rnd_core_b", core_b, p_b);
      end

      req_valid = ($urandom_range(0, 2) != 0);
      req_tag = 4'($urandom);
      operation = 5'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      rsp_ready = ($urandom_range(0, 2) == 0);
      if (done_at.exists(cyc)) begin
        core_done = 1'b1;
        core_out = (outst && cyc == t_res && !p_to) ? p_res : 16'($urandom);
      end else begin
        core_done = !outst && ($urandom_range(0, 7) == 0);
        core_out = 16'($urandom);
      end

      acc = req_valid && e_ready;
      if (rsp_ready && expq.size() != 0) void'(expq.pop_front());
      if (outst && cyc == t_res) begin
        r.tag = p_tag;
        r.to = p_to;
        r.out = p_to ? 32'h0000_7E00 : {{16{p_res[15]}}, p_res};
        expq.push_back(r);
        outst = 1'b0;
      end
      if (acc) begin
        lat = $urandom_range(1, 10);
        outst = 1'b1;
        t_acc = cyc;
        p_tag = req_tag;
        p_op = operation;
        p_a = req_a[15:0];
        p_b = req_b[15:0];
        p_res = 16'($urandom);
        done_at[cyc + 1 + lat] = 1'b1;
        if (lat <= TMO) begin
          t_res = cyc + 1 + lat;
          p_to = 1'b0;
        end else begin
          t_res = cyc + 1 + TMO;
          p_to = 1'b1;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
